// File: rtl/aes_pkg.sv
// Shared definitions for the byte-serial MixColumns sequencer: FSM encoding,
// state geometry and byte/column addressing into a big-endian 128-bit AES state.
package aes_pkg;

  localparam int STATE_W   = 128;
  localparam int BYTE_W    = 8;
  localparam int COL_W     = 32;
  localparam int NUM_BYTES = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

  // Byte k sits at the most-significant end for k=0.
  function automatic logic [BYTE_W-1:0] state_byte(input logic [STATE_W-1:0] s,
                                                   input logic [3:0] k);
    return s[STATE_W-1 - BYTE_W*k -: BYTE_W];
  endfunction

  function automatic logic [STATE_W-1:0] set_column(input logic [STATE_W-1:0] s,
                                                    input logic [1:0] c,
                                                    input logic [COL_W-1:0] col);
    logic [STATE_W-1:0] r;
    r = s;
    r[STATE_W-1 - COL_W*c -: COL_W] = col;
    return r;
  endfunction

endpackage

// File: rtl/mc_col_acc.sv
// Column accumulator: rotates the four datapath products by the byte's row
// position j and XOR-folds them into a 4-byte running column.
module mc_col_acc
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        j,
  input  logic [BYTE_W-1:0] prod_1,
  input  logic [BYTE_W-1:0] prod_2,
  input  logic [BYTE_W-1:0] prod_3,
  input  logic [BYTE_W-1:0] prod_4,
  output logic [COL_W-1:0]  col_out
);

  logic [3:0][BYTE_W-1:0] prod;
  logic [3:0][BYTE_W-1:0] contrib;
  logic [3:0][BYTE_W-1:0] acc_q;
  logic [1:0]             sel;

  // Row i takes product ((i - j) mod 4): the 2-bit subtraction supplies the wrap.
  always_comb begin
    prod    = {prod_4, prod_3, prod_2, prod_1};
    contrib = '0;
    sel     = '0;
    for (int i = 0; i < 4; i++) begin
      sel        = 2'(i) - j;
      contrib[i] = prod[sel];
    end
  end

  assign col_out = {acc_q[0] ^ contrib[0], acc_q[1] ^ contrib[1],
                    acc_q[2] ^ contrib[2], acc_q[3] ^ contrib[3]};

  // The last byte of a column completes it, so the accumulator restarts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= (j == 2'd3) ? '0 : (acc_q ^ contrib);
    end
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequencer feeding an AES state byte-serially through the MixColumns datapath
// and assembling the mixed columns; a bypass request returns the state unmixed.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int              EN_W  = 8,
  parameter logic [EN_W-1:0] EN_ON = {EN_W{1'b1}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] state_in,
  input  logic               bypass,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state_out,
  output logic [BYTE_W-1:0]  mc_in_byte,
  output logic [EN_W-1:0]    mc_enable,
  input  logic [BYTE_W-1:0]  mc_out_1,
  input  logic [BYTE_W-1:0]  mc_out_2,
  input  logic [BYTE_W-1:0]  mc_out_3,
  input  logic [BYTE_W-1:0]  mc_out_4
);

  mc_state_e          state_q, state_d;
  logic [3:0]         cnt_q;
  logic [STATE_W-1:0] cap_q;
  logic [STATE_W-1:0] out_q;
  logic [COL_W-1:0]   col_out;
  logic               accept;
  logic               running;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = bypass ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (cnt_q == 4'd15) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept  = in_valid && (state_q == ST_IDLE);
  assign running = (state_q == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept && !bypass) cnt_q <= '0;
      else if (running)      cnt_q <= cnt_q + 4'd1;
    end
  end

  // Working copy of the input; only meaningful while running, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept && !bypass) cap_q <= state_in;
  end

  assign mc_in_byte = running ? state_byte(cap_q, cnt_q) : '0;
  assign mc_enable  = running ? EN_ON : '0;

  mc_col_acc u_col_acc (
    .clk     (clk),
    .rst     (rst),
    .en      (running),
    .j       (cnt_q[1:0]),
    .prod_1  (mc_out_1),
    .prod_2  (mc_out_2),
    .prod_3  (mc_out_3),
    .prod_4  (mc_out_4),
    .col_out (col_out)
  );

  // Columns land one at a time as they complete; DONE holds the register untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else if (accept && bypass) begin
      out_q <= state_in;
    end else if (running && (cnt_q[1:0] == 2'd3)) begin
      out_q <= set_column(out_q, cnt_q[3:2], col_out);
    end
  end

  assign state_out = out_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq with a behavioural GF(2^8) datapath on the mc_* ports
// and an independent full-state MixColumns reference feeding a scoreboard.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] state_in = '0;
  logic         bypass = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] state_out;
  logic [7:0]   mc_in_byte;
  logic [7:0]   mc_enable;
  logic [7:0]   mc_out_1, mc_out_2, mc_out_3, mc_out_4;

  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] sb[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign mc_out_1 = xt(mc_in_byte);
  assign mc_out_2 = mc_in_byte;
  assign mc_out_3 = mc_in_byte;
  assign mc_out_4 = xt(mc_in_byte) ^ mc_in_byte;

  mix_columns_seq #(.EN_W(8), .EN_ON(8'hFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .state_in   (state_in),
    .bypass     (bypass),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .state_out  (state_out),
    .mc_in_byte (mc_in_byte),
    .mc_enable  (mc_enable),
    .mc_out_1   (mc_out_1),
    .mc_out_2   (mc_out_2),
    .mc_out_3   (mc_out_3),
    .mc_out_4   (mc_out_4)
  );

  function automatic logic [7:0] byte_of(input logic [127:0] s, input int k);
    return s[127 - 8*k -: 8];
  endfunction

  function automatic logic [127:0] mc_ref(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = byte_of(s, 4*c);
      a1 = byte_of(s, 4*c + 1);
      a2 = byte_of(s, 4*c + 2);
      a3 = byte_of(s, 4*c + 3);
      r[127 - 32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                             xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " in_ready"},   in_ready,   1);
    check({tag, " out_valid"},  out_valid,  0);
    check({tag, " state_out"},  state_out,  0);
    check({tag, " mc_in_byte"}, mc_in_byte, 0);
    check({tag, " mc_enable"},  mc_enable,  0);
  endtask

  // Waits for out_valid after an accept edge, tracing the byte feed on the way.
  task automatic wait_result(input logic [127:0] s, input logic byp, input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      if (n < 16) begin
        check({tag, " mc_in_byte"}, mc_in_byte, byte_of(s, n));
        check({tag, " mc_enable"},  mc_enable,  8'hFF);
      end
      @(posedge clk); #1;
      n++;
    end
    if (byp) check({tag, " bypass mc_enable"}, mc_enable, 8'h00);
    check({tag, " latency"}, n, byp ? 0 : 16);
    if (out_valid) begin
      check({tag, " state_out"}, state_out, sb.pop_front());
    end else begin
      check({tag, " out_valid timeout"}, 0, 1);
      void'(sb.pop_front());
    end
  endtask

  task automatic xact(input logic [127:0] s, input logic byp, input logic [127:0] exp,
                      input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check({tag, " in_ready timeout"}, 0, 1);
      return;
    end
    in_valid = 1'b1;
    state_in = s;
    bypass   = byp;
    sb.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    bypass   = 1'b0;
    wait_result(s, byp, tag);
    @(posedge clk); #1;
    check({tag, " out_valid drop"}, out_valid, 0);
  endtask

  typedef struct {
    logic [127:0] s;
    logic         byp;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [127:0] sa, sb_in, sc, ea, rs;

    vecs[0] = '{128'hdb135345_00000000_00000000_00000000, 1'b0,
                128'h8e4da1bc_00000000_00000000_00000000};
    vecs[1] = '{128'hd4bf5d30_f20a225c_c6c6c6c6_01010102, 1'b0,
                128'h046681e5_9fdc589d_c6c6c6c6_02020407};
    vecs[2] = '{128'h00112233_44556677_8899aabb_ccddeeff, 1'b1,
                128'h00112233_44556677_8899aabb_ccddeeff};
    vecs[3] = '{128'h0, 1'b0, 128'h0};
    vecs[4] = '{128'h01010101_01010101_01010101_01010101, 1'b0,
                128'h01010101_01010101_01010101_01010101};

    #12;
    check_reset_outputs("in reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("after reset");

    for (int i = 0; i < 5; i++) xact(vecs[i].s, vecs[i].byp, vecs[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 4; i++) begin
      rs = {$urandom, $urandom, $urandom, $urandom};
      xact(rs, 1'b0, mc_ref(rs), $sformatf("rand%0d", i));
    end
    rs = {$urandom, $urandom, $urandom, $urandom};
    xact(rs, 1'b1, rs, "rand bypass");

    // Back-pressure in DONE plus a second request held through RUN/DONE.
    sa    = vecs[1].s;
    ea    = mc_ref(sa);
    sb_in = 128'h2d26314c_01010101_d4d4d4d5_db135345;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    state_in  = sa;
    bypass    = 1'b0;
    sb.push_back(ea);
    @(posedge clk); #1;
    state_in = sb_in;
    begin
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
        check("hold in_ready in RUN", in_ready, 0);
        @(posedge clk); #1;
        n++;
      end
      check("hold latency", n, 16);
    end
    check("hold state_out", state_out, sb.pop_front());
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("hold out_valid", out_valid, 1);
      check("hold state_out stable", state_out, ea);
      check("hold in_ready in DONE", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release in_ready", in_ready, 1);
    check("release out_valid", out_valid, 0);
    sb.push_back(mc_ref(sb_in));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("second accept in_ready", in_ready, 0);
    wait_result(sb_in, 1'b0, "second");
    @(posedge clk); #1;
    check("second out_valid drop", out_valid, 0);

    // Asynchronous reset in the middle of a RUN.
    sc = vecs[1].s;
    @(negedge clk);
    in_valid = 1'b1;
    state_in = sc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 7; k++) @(posedge clk);
    #1;
    check("pre-reset mc_in_byte cnt7", mc_in_byte, byte_of(sc, 7));
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("mid-run reset");
    @(negedge clk);
    rst = 1'b0;
    xact(vecs[4].s, 1'b0, vecs[4].exp, "post-reset");

    check("scoreboard empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
